// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between writeback (A) and a long-latency unit (B).
// It also keeps B's outstanding-destination scoreboard. Optional perf counters: RFARB_PERF_EN.
module rf_write_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned WAIT_W   = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        mcu_valid,
  input  logic [4:0]  mcu_addr,
  input  logic [31:0] mcu_data,
  output logic        mcu_gnt,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  input  logic        dec_use1,
  input  logic        dec_use2,
  input  logic        dec_wr,
  input  logic [4:0]  dec_rd,
  output logic        hz_stall,
  output logic        arb_stall,
  output logic        rfwrite,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic [31:0] pending
`ifdef RFARB_PERF_EN
  ,
  output logic [CNT_W-1:0] conf_cnt,
  output logic [CNT_W-1:0] force_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  localparam logic [WAIT_W-1:0] MAX_W    = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
  localparam bit                ONE_WAIT = (MAX_WAIT <= 1);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt, wait_inc;
  logic              sel_a, sel_b;
  logic [31:0]       set_vec, clr_vec, pending_nxt;

  assign wait_inc = wait_cnt + WAIT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    sel_a     = 1'b0;
    sel_b     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wb_valid) begin
          sel_a = 1'b1;
          if (mcu_valid) begin
            if (ONE_WAIT) begin
              state_nxt = ST_FORCE;
              wait_nxt  = WAIT_ONE;
            end else begin
              state_nxt = ST_WAIT;
              wait_nxt  = WAIT_ONE;
            end
          end
        end else if (mcu_valid) begin
          sel_b = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!wb_valid) begin
          sel_b     = mcu_valid;
          state_nxt = ST_IDLE;
          wait_nxt  = '0;
        end else begin
          sel_a = 1'b1;
          if (!mcu_valid) begin
            state_nxt = ST_IDLE;
            wait_nxt  = '0;
          end else begin
            wait_nxt = wait_inc;
            if (wait_inc >= MAX_W) state_nxt = ST_FORCE;
          end
        end
      end
      ST_FORCE: begin
        sel_b     = mcu_valid;
        state_nxt = ST_IDLE;
        wait_nxt  = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        wait_nxt  = '0;
      end
    endcase
    // Grants are gated so the write port is quiet while reset is held, even with requests present.
    if (!rst_n) begin
      sel_a = 1'b0;
      sel_b = 1'b0;
    end
  end

  assign mcu_gnt   = sel_b;
  assign arb_stall = (state == ST_FORCE);

  always_comb begin
    rfwrite = 1'b0;
    waddr   = '0;
    wdata   = '0;
    if (sel_a) begin
      rfwrite = (wb_addr != 5'd0);
      waddr   = wb_addr;
      wdata   = wb_data;
    end else if (sel_b) begin
      rfwrite = (mcu_addr != 5'd0);
      waddr   = mcu_addr;
      wdata   = mcu_data;
    end
  end

  // Set is applied after clear so a same-cycle issue to the granted register keeps it pending.
  always_comb begin
    set_vec     = '0;
    clr_vec     = '0;
    if (iss_valid) set_vec = 32'd1 << iss_rd;
    if (mcu_gnt)   clr_vec = 32'd1 << mcu_addr;
    pending_nxt = ((pending & ~clr_vec) | set_vec) & ~32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  assign hz_stall = (dec_use1 & pending[raddr1]) |
                    (dec_use2 & pending[raddr2]) |
                    (dec_wr   & pending[dec_rd]);

`ifdef RFARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conf_cnt  <= '0;
      force_cnt <= '0;
    end else begin
      if (wb_valid && mcu_valid && (conf_cnt != '1))
        conf_cnt <= conf_cnt + CNT_W'(1);
      if ((state_nxt == ST_FORCE) && (state != ST_FORCE) && (force_cnt != '1))
        force_cnt <= force_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: write-port expectations are queued as stimulus is driven
// and popped when the cycle's outputs are sampled on the negedge.
module tb_rf_write_arbiter;

  logic        clk, rst_n;
  logic        wb_valid, mcu_valid, iss_valid;
  logic [4:0]  wb_addr, mcu_addr, iss_rd, raddr1, raddr2, dec_rd, waddr;
  logic [31:0] wb_data, mcu_data, wdata, pending;
  logic        dec_use1, dec_use2, dec_wr;
  logic        mcu_gnt, hz_stall, arb_stall, rfwrite;
`ifdef RFARB_PERF_EN
  logic [15:0] conf_cnt, force_cnt;
`endif

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t wq[$];

  rf_write_arbiter #(.MAX_WAIT(4), .WAIT_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .mcu_valid(mcu_valid), .mcu_addr(mcu_addr), .mcu_data(mcu_data), .mcu_gnt(mcu_gnt),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .raddr1(raddr1), .raddr2(raddr2), .dec_use1(dec_use1), .dec_use2(dec_use2),
    .dec_wr(dec_wr), .dec_rd(dec_rd),
    .hz_stall(hz_stall), .arb_stall(arb_stall),
    .rfwrite(rfwrite), .waddr(waddr), .wdata(wdata), .pending(pending)
`ifdef RFARB_PERF_EN
    , .conf_cnt(conf_cnt), .force_cnt(force_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic set_in(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md);
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    mcu_valid = mv; mcu_addr = ma; mcu_data = md;
  endtask

  task automatic set_iss(input logic v, input logic [4:0] rd);
    iss_valid = v; iss_rd = rd;
  endtask

  task automatic set_dec(input logic u1, input logic [4:0] r1, input logic u2,
                         input logic [4:0] r2, input logic w, input logic [4:0] rd);
    dec_use1 = u1; raddr1 = r1; dec_use2 = u2; raddr2 = r2; dec_wr = w; dec_rd = rd;
  endtask

  task automatic cycle(input string tag, input logic e_gnt, input logic e_stall,
                       input logic e_hz, input logic e_wr, input logic [4:0] e_addr,
                       input logic [31:0] e_data);
    wr_t e;
    if (e_wr) begin
      e.a = e_addr;
      e.d = e_data;
      wq.push_back(e);
    end
    @(negedge clk);
    chk({tag, " mcu_gnt"},   32'(mcu_gnt),   32'(e_gnt));
    chk({tag, " arb_stall"}, 32'(arb_stall), 32'(e_stall));
    chk({tag, " hz_stall"},  32'(hz_stall),  32'(e_hz));
    chk({tag, " rfwrite"},   32'(rfwrite),   32'(e_wr));
    if (e_wr) begin
      e = wq.pop_front();
      chk({tag, " waddr"}, 32'(waddr), 32'(e.a));
      chk({tag, " wdata"}, wdata, e.d);
    end else if (!wb_valid && !mcu_valid) begin
      chk({tag, " idle waddr"}, 32'(waddr), 32'd0);
      chk({tag, " idle wdata"}, wdata, 32'd0);
    end
    if (mcu_valid && (mcu_addr != 5'd0))
      chk({tag, " b dest pending"}, 32'(pending[mcu_addr]), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    set_iss(0, 0);
    set_dec(0, 0, 0, 0, 0, 0);
    #2;
    chk("rst pending", pending, 32'd0);
    chk("rst arb_stall", 32'(arb_stall), 32'd0);
    chk("rst mcu_gnt", 32'(mcu_gnt), 32'd0);
    chk("rst rfwrite", 32'(rfwrite), 32'd0);
    chk("rst waddr", 32'(waddr), 32'd0);
    chk("rst wdata", wdata, 32'd0);
    chk("rst hz_stall", 32'(hz_stall), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    cycle("idle", 0, 0, 0, 0, 0, 0);

    // B alone to r5, with decode reading r5 during the grant cycle
    set_iss(1, 5);
    cycle("iss5", 0, 0, 0, 0, 0, 0);
    chk("pend after iss5", pending, 32'h0000_0020);
    set_iss(0, 0);
    set_in(0, 0, 0, 1, 5, 32'hDEAD_BEEF);
    set_dec(1, 5, 0, 0, 0, 0);
    cycle("b5", 1, 0, 1, 1, 5, 32'hDEAD_BEEF);
    chk("pend after b5", pending, 32'd0);
    set_in(0, 0, 0, 0, 0, 0);
    cycle("b5 release", 0, 0, 0, 0, 0, 0);

    // RAW/WAW on r7, stall lasts through the grant cycle
    set_dec(0, 0, 0, 0, 0, 0);
    set_iss(1, 7);
    cycle("iss7", 0, 0, 0, 0, 0, 0);
    set_iss(0, 0);
    set_dec(1, 7, 0, 0, 0, 0);
    cycle("raw7 src1", 0, 0, 1, 0, 0, 0);
    set_dec(0, 0, 1, 7, 0, 0);
    cycle("raw7 src2", 0, 0, 1, 0, 0, 0);
    set_dec(0, 0, 0, 0, 1, 7);
    cycle("waw7", 0, 0, 1, 0, 0, 0);
    set_dec(1, 7, 0, 0, 0, 0);
    set_in(0, 0, 0, 1, 7, 32'h0000_0077);
    cycle("gnt7", 1, 0, 1, 1, 7, 32'h0000_0077);
    set_in(0, 0, 0, 0, 0, 0);
    cycle("rel7", 0, 0, 0, 0, 0, 0);
    set_dec(0, 0, 0, 0, 0, 0);

    // same-cycle issue and grant of r7: set wins
    set_iss(1, 7);
    cycle("iss7b", 0, 0, 0, 0, 0, 0);
    set_in(0, 0, 0, 1, 7, 32'h0000_7777);
    cycle("setclr7", 1, 0, 0, 1, 7, 32'h0000_7777);
    chk("pend setclr7", pending, 32'h0000_0080);
    set_iss(0, 0);
    set_in(0, 0, 0, 1, 7, 32'h0000_7778);
    cycle("clr7", 1, 0, 0, 1, 7, 32'h0000_7778);
    chk("pend clr7", pending, 32'd0);

    // x0 handling
    set_in(0, 0, 0, 1, 0, 32'h0000_1234);
    cycle("b x0", 1, 0, 0, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 0);
    set_iss(1, 0);
    set_dec(1, 0, 0, 0, 1, 0);
    cycle("iss x0", 0, 0, 0, 0, 0, 0);
    chk("pend iss x0", pending, 32'd0);
    set_iss(0, 0);
    set_dec(0, 0, 0, 0, 0, 0);
    set_in(1, 0, 32'h5, 0, 0, 0);
    cycle("a x0", 0, 0, 0, 0, 0, 0);
    set_in(1, 3, 32'h1111, 0, 0, 0);
    cycle("a3", 0, 0, 0, 1, 3, 32'h1111);

    // full conflict: A wins 4 cycles, then FORCE grants B
    set_in(0, 0, 0, 0, 0, 0);
    set_iss(1, 9);
    cycle("iss9", 0, 0, 0, 0, 0, 0);
    set_iss(0, 0);
    for (int i = 0; i < 4; i++) begin
      set_in(1, 5'(1 + i), 32'(32'hA0 + i), 1, 9, 32'hB9);
      cycle($sformatf("conf%0d", i), 0, 0, 0, 1, 5'(1 + i), 32'(32'hA0 + i));
    end
    set_in(1, 4, 32'hA3, 1, 9, 32'hB9);
    cycle("force9", 1, 1, 0, 1, 9, 32'hB9);
    chk("pend force9", pending, 32'd0);
    set_in(1, 4, 32'hA3, 0, 0, 0);
    cycle("after force9", 0, 0, 0, 1, 4, 32'hA3);

    // A drops while B waits: B granted, wait count restarts
    set_in(0, 0, 0, 0, 0, 0);
    set_iss(1, 10);
    cycle("iss10", 0, 0, 0, 0, 0, 0);
    set_iss(0, 0);
    set_in(1, 2, 32'hC0, 1, 10, 32'h10A);
    cycle("drop c0", 0, 0, 0, 1, 2, 32'hC0);
    set_in(1, 3, 32'hC1, 1, 10, 32'h10A);
    cycle("drop c1", 0, 0, 0, 1, 3, 32'hC1);
    set_in(0, 0, 0, 1, 10, 32'h10A);
    set_iss(1, 11);
    cycle("drop gnt10", 1, 0, 0, 1, 10, 32'h10A);
    chk("pend drop", pending, 32'h0000_0800);
    set_iss(0, 0);
    for (int k = 0; k < 4; k++) begin
      set_in(1, 5'(12 + k), 32'(32'hD0 + k), 1, 11, 32'h11B);
      cycle($sformatf("rewait%0d", k), 0, 0, 0, 1, 5'(12 + k), 32'(32'hD0 + k));
    end
    set_in(1, 15, 32'hD3, 1, 11, 32'h11B);
    cycle("force11", 1, 1, 0, 1, 11, 32'h11B);
    set_in(1, 15, 32'hD3, 0, 0, 0);
    cycle("after force11", 0, 0, 0, 1, 15, 32'hD3);

    // async reset while in WAIT with pending r7/r10
    set_in(0, 0, 0, 0, 0, 0);
    set_iss(1, 7);
    cycle("iss7c", 0, 0, 0, 0, 0, 0);
    set_iss(1, 10);
    cycle("iss10c", 0, 0, 0, 0, 0, 0);
    set_iss(0, 0);
    set_in(1, 1, 32'h1, 1, 7, 32'h7);
    cycle("pre rst", 0, 0, 0, 1, 1, 32'h1);
    chk("pend pre rst", pending, 32'h0000_0480);
`ifdef RFARB_PERF_EN
    chk("conf_cnt pre rst", 32'(conf_cnt), 32'd13);
    chk("force_cnt pre rst", 32'(force_cnt), 32'd2);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("midrst pending", pending, 32'd0);
    chk("midrst arb_stall", 32'(arb_stall), 32'd0);
    chk("midrst mcu_gnt", 32'(mcu_gnt), 32'd0);
    chk("midrst rfwrite", 32'(rfwrite), 32'd0);
`ifdef RFARB_PERF_EN
    chk("midrst conf_cnt", 32'(conf_cnt), 32'd0);
    chk("midrst force_cnt", 32'(force_cnt), 32'd0);
`endif
    set_in(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // after reset the wait count starts from zero again
    set_iss(1, 7);
    cycle("post iss7", 0, 0, 0, 0, 0, 0);
    set_iss(0, 0);
    for (int j = 0; j < 4; j++) begin
      set_in(1, 5'(20 + j), 32'(32'hE0 + j), 1, 7, 32'h70);
      cycle($sformatf("post conf%0d", j), 0, 0, 0, 1, 5'(20 + j), 32'(32'hE0 + j));
    end
    set_in(1, 23, 32'hE3, 1, 7, 32'h70);
    cycle("post force7", 1, 1, 0, 1, 7, 32'h70);
    set_in(1, 23, 32'hE3, 0, 0, 0);
    cycle("post after force", 0, 0, 0, 1, 23, 32'hE3);
    chk("pend final", pending, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
